// File: rtl/aud_pkg.sv
// Shared types and constants for the audio sample scheduler.
package aud_pkg;

    localparam int AUD_FRAME_CYCLES = 256;
    localparam int AUD_DATA_WIDTH   = 16;

    typedef enum logic [1:0] {
        SRC_SIN   = 2'd0,
        SRC_FLASH = 2'd1,
        SRC_SDRAM = 2'd2,
        SRC_SRAM  = 2'd3
    } aud_src_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ_L = 2'd1,
        ST_REQ_R = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/aud_frame_timer.sv
// Free-running frame counter; oBoundary marks the last cycle of each frame.
module aud_frame_timer #(
    parameter int FRAME_CYCLES = 256,
    parameter int CW           = $clog2(FRAME_CYCLES)
) (
    input  logic          iCLK_18_4,
    input  logic          iRST_N,
    output logic [CW-1:0] oCnt,
    output logic          oBoundary
);

    localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign oCnt      = cnt_q;
    assign oBoundary = (cnt_q == LAST);

endmodule

// File: rtl/aud_sample_sched.sv
// Per-frame L/R sample fetch and serializer load with underrun repeat.
// Optional underrun counter: define AUD_SCHED_UNDERRUN_CNT_EN.
module aud_sample_sched
    import aud_pkg::*;
#(
    parameter int FRAME_CYCLES = AUD_FRAME_CYCLES,
    parameter int DATA_WIDTH   = AUD_DATA_WIDTH,
    parameter int ADDR_WIDTH   = 22,
    parameter int DEPTH        = 4194304
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST_N,
    input  logic                  iEnable,
    input  logic [1:0]            iSrc_Select,
    output logic                  oReq,
    output logic [1:0]            oReq_Src,
    output logic [ADDR_WIDTH-1:0] oReq_Addr,
    input  logic                  iAck,
    input  logic [DATA_WIDTH-1:0] iData,
    output logic                  oLoad,
    output logic [DATA_WIDTH-1:0] oLeft,
    output logic [DATA_WIDTH-1:0] oRight,
    output logic                  oUnderrun,
    input  logic                  iClr_Underrun,
    output logic [7:0]            oUnderrun_Cnt
);

    localparam int CW = $clog2(FRAME_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 2);

    logic [CW-1:0] frame_cnt;
    logic          bnd;
    logic          unused_cnt;

    aud_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
        .iCLK_18_4 (iCLK_18_4),
        .iRST_N    (iRST_N),
        .oCnt      (frame_cnt),
        .oBoundary (bnd)
    );

    assign unused_cnt = ^frame_cnt;

    sched_state_e          state_q, state_d;
    aud_src_e              src_q, src_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_nxt;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [DATA_WIDTH-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
    logic                  load_q, load_d;
    logic                  unf_q, unf_d, set_unf;

    assign addr_nxt = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_WIDTH'(2);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        src_d   = src_q;
        left_d  = left_q;
        buf_l_d = buf_l_q;
        buf_r_d = buf_r_q;
        out_l_d = out_l_q;
        out_r_d = out_r_q;
        load_d  = 1'b0;
        set_unf = 1'b0;
        // Request is raised one cycle after entering a REQ state, so it always idles low between words.
        unique case (state_q)
            ST_REQ_L, ST_REQ_R: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (iAck) begin
                    req_d = 1'b0;
                    if (state_q == ST_REQ_L) begin
                        left_d  = iData;
                        state_d = ST_REQ_R;
                    end else begin
                        buf_l_d = left_q;
                        buf_r_d = iData;
                        addr_d  = addr_nxt;
                        state_d = ST_DONE;
                    end
                end
            end
            default: ;
        endcase
        if (bnd) begin
            load_d  = 1'b1;
            req_d   = 1'b0;
            out_l_d = iEnable ? buf_l_d : '0;
            out_r_d = iEnable ? buf_r_d : '0;
            set_unf = (state_d == ST_REQ_L) || (state_d == ST_REQ_R);
            if (iSrc_Select != src_q) begin
                src_d  = aud_src_e'(iSrc_Select);
                addr_d = '0;
            end
            state_d = iEnable ? ST_REQ_L : ST_IDLE;
        end
        unf_d = set_unf | (unf_q & ~iClr_Underrun);
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
            src_q   <= SRC_SIN;
            req_q   <= 1'b0;
            addr_q  <= '0;
            left_q  <= '0;
            buf_l_q <= '0;
            buf_r_q <= '0;
            out_l_q <= '0;
            out_r_q <= '0;
            load_q  <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            buf_l_q <= buf_l_d;
            buf_r_q <= buf_r_d;
            out_l_q <= out_l_d;
            out_r_q <= out_r_d;
            load_q  <= load_d;
            unf_q   <= unf_d;
        end
    end

`ifdef AUD_SCHED_UNDERRUN_CNT_EN
    logic [7:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (set_unf)            ucnt_d = iClr_Underrun ? 8'd1 :
                                         (ucnt_q == 8'hFF) ? ucnt_q : ucnt_q + 8'd1;
        else if (iClr_Underrun) ucnt_d = '0;
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) ucnt_q <= '0;
        else         ucnt_q <= ucnt_d;
    end

    assign oUnderrun_Cnt = ucnt_q;
`else
    assign oUnderrun_Cnt = '0;
`endif

    assign oReq      = req_q;
    assign oReq_Src  = req_q ? src_q : 2'd0;
    assign oReq_Addr = !req_q ? '0 :
                       (state_q == ST_REQ_R) ? addr_q + ADDR_WIDTH'(1) : addr_q;
    assign oLoad     = load_q;
    assign oLeft     = out_l_q;
    assign oRight    = out_r_q;
    assign oUnderrun = unf_q;

endmodule

// File: tb/tb_aud_sample_sched.sv
// Randomized bench for aud_sample_sched against a frame-level reference model.
module tb_aud_sample_sched;

    localparam int FC    = 256;
    localparam int DW    = 16;
    localparam int AW    = 22;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, ack, clr;
    logic [1:0]    src;
    logic [DW-1:0] data;
    logic          oReq, oLoad, oUnderrun;
    logic [1:0]    oReq_Src;
    logic [AW-1:0] oReq_Addr;
    logic [DW-1:0] oLeft, oRight;
    logic [7:0]    oUnderrun_Cnt;

    always #5 clk = ~clk;

    aud_sample_sched #(
        .FRAME_CYCLES(FC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
    ) dut (
        .iCLK_18_4     (clk),
        .iRST_N        (rst_n),
        .iEnable       (en),
        .iSrc_Select   (src),
        .oReq          (oReq),
        .oReq_Src      (oReq_Src),
        .oReq_Addr     (oReq_Addr),
        .iAck          (ack),
        .iData         (data),
        .oLoad         (oLoad),
        .oLeft         (oLeft),
        .oRight        (oRight),
        .oUnderrun     (oUnderrun),
        .iClr_Underrun (clr),
        .oUnderrun_Cnt (oUnderrun_Cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: words fetched this frame, address, buffered pair.
    int          m_tick, m_addr, m_got, m_ucnt;
    logic [1:0]  m_src;
    logic [DW-1:0] m_bl, m_br, m_tl, e_l, e_r;
    bit          m_fetch, m_unf, e_load, chk_unf, last_acked;
    int          mode, lat, hi_cnt;
    bit          prev_req, force_ack;
    logic [AW-1:0] rq_addr;
    logic [1:0]  rq_src;

    function automatic int exp_ucnt();
`ifdef AUD_SCHED_UNDERRUN_CNT_EN
        return m_ucnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_tick = 0; m_addr = 0; m_got = 0; m_ucnt = 0; m_src = 2'd0;
        m_bl = '0; m_br = '0; m_tl = '0; m_fetch = 0; m_unf = 0;
        e_load = 0; chk_unf = 0; last_acked = 0;
        prev_req = 0; hi_cnt = 0; mode = 0; lat = 3;
    endtask

    task automatic checks();
        if (e_load) begin
            check("load", oLoad, 1);
            check("left", oLeft, e_l);
            check("right", oRight, e_r);
        end else if (oLoad) begin
            check("load_spurious", oLoad, 0);
        end
        if (e_load || chk_unf) begin
            check("underrun", oUnderrun, m_unf);
            check("underrun_cnt", oUnderrun_Cnt, exp_ucnt());
        end
        if (last_acked) check("req_gap", oReq, 0);
        if (oReq && !prev_req) begin
            check("req_allowed", (m_fetch && m_got < 2), 1);
            check("req_addr", oReq_Addr, (m_addr + m_got) % DEPTH);
            check("req_src", oReq_Src, m_src);
            rq_addr = oReq_Addr;
            rq_src  = oReq_Src;
            lat     = $urandom_range(1, 6);
        end else if (oReq) begin
            check("req_addr_hold", oReq_Addr, rq_addr);
            check("req_src_hold", oReq_Src, rq_src);
        end
        prev_req = oReq;
    endtask

    task automatic drive_and_model();
        bit bnd, acked, set;
        bnd = (m_tick == FC - 1);
        hi_cnt = oReq ? hi_cnt + 1 : 0;
        if (m_tick == 0) begin
            case ($urandom % 8)
                5:       mode = 1;
                6:       mode = 2;
                7:       mode = 3;
                default: mode = 0;
            endcase
        end
        if (m_tick == 100) begin
            en = ($urandom % 5) != 0;
            if ($urandom % 3 == 0) src = 2'($urandom);
        end
        clr = (m_tick == 150) && ($urandom % 4 == 0);
        case (mode)
            1:       ack = 1'b0;
            2:       ack = oReq && ((m_got == 0) ? hi_cnt >= lat : bnd);
            3:       ack = oReq && bnd && m_got == 0;
            default: ack = oReq && hi_cnt >= lat;
        endcase
        if (!oReq && ($urandom % 8 == 0)) ack = 1'b1;
        if (force_ack) ack = 1'b1;
        force_ack = 0;
        data = DW'($urandom);

        acked = ack && oReq;
        last_acked = acked;
        if (acked && m_fetch) begin
            if (m_got == 0) begin
                m_tl = data; m_got = 1;
            end else if (m_got == 1) begin
                m_bl = m_tl; m_br = data; m_got = 2;
                m_addr = (m_addr + 2) % DEPTH;
            end
        end
        set = 0;
        e_load = bnd;
        if (bnd) begin
            e_l = en ? m_bl : '0;
            e_r = en ? m_br : '0;
            set = m_fetch && m_got < 2;
            m_fetch = en;
            m_got = 0;
            if (src != m_src) begin
                m_src = src; m_addr = 0;
            end
        end
        if (set) begin
            m_unf = 1;
            m_ucnt = clr ? 1 : (m_ucnt < 255 ? m_ucnt + 1 : 255);
        end else if (clr) begin
            m_unf = 0; m_ucnt = 0;
        end
        chk_unf = clr || bnd;
        m_tick = (m_tick + 1) % FC;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks();
            drive_and_model();
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; en = 1'b1; src = 2'd2; ack = 1'b0; clr = 1'b0; data = '0;
        force_ack = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_load", oLoad, 0);
        check("rst_req", oReq, 0);
        check("rst_unf", oUnderrun, 0);
        rst_n = 1'b1;
        drive_and_model();
        run_cycles(FC * 24);

        found = 0;
        for (int i = 0; i < 2 * FC && !found; i++) begin
            @(negedge clk);
            checks();
            drive_and_model();
            found = oReq;
        end
        check("rst_wait_req", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_req", oReq, 0);
        check("rst_async_addr", oReq_Addr, 0);
        check("rst_async_load", oLoad, 0);
        check("rst_async_left", oLeft, 0);
        check("rst_async_right", oRight, 0);
        check("rst_async_unf", oUnderrun, 0);
        check("rst_async_cnt", oUnderrun_Cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        force_ack = 1;
        drive_and_model();
        run_cycles(FC * 24);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
